// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - Stereo I2S transmitter with a one-deep pending frame register
// All outputs are registered; serial state advances only on sclk fall events.
module audio_i2s_tx #(
  parameter int SCLK_DIV         = 4,
  parameter int SLOT_BITS        = 16,
  parameter int MUTE_ON_UNDERRUN = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        frame_start,
  output logic        underrun,
  output logic        overrun,
  output logic        i2s_sclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);
  // Position at which the slot's LSB is known to be final; feeds the next slot's delayed bit.
  localparam logic [BW-1:0] LB_POS   = BW'((SLOT_BITS > 16) ? 16 : SLOT_BITS - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          sclk_q, sclk_d;
  logic          lrck_q, lrck_d;
  logic          sdata_q, sdata_d;
  logic          last_bit_q, last_bit_d;
  logic [31:0]   frame_q, frame_d;
  logic [31:0]   pending_q, pending_d;
  logic          pending_valid_q, pending_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          underrun_q, underrun_d;
  logic          overrun_q, overrun_d;

  logic          tick, fall, load, slot, ser_bit;
  logic [BW-1:0] bit_next, pos;
  logic [31:0]   frame_nxt;
  logic [15:0]   sample;

  always_comb begin
    div_cnt_d       = div_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    sclk_d          = sclk_q;
    lrck_d          = lrck_q;
    sdata_d         = sdata_q;
    last_bit_d      = last_bit_q;
    frame_d         = frame_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    frame_start_d   = 1'b0;
    underrun_d      = 1'b0;
    overrun_d       = 1'b0;

    tick     = (div_cnt_q == DIV_LAST);
    fall     = tick & sclk_q;
    load     = fall & (bit_cnt_q == BIT_LAST);
    bit_next = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    slot     = (bit_next >= SLOT_LEN);
    pos      = slot ? bit_next - SLOT_LEN : bit_next;

    frame_nxt = frame_q;
    if (load) begin
      if (pending_valid_q)            frame_nxt = pending_q;
      else if (MUTE_ON_UNDERRUN != 0) frame_nxt = '0;
    end
    sample = slot ? frame_nxt[15:0] : frame_nxt[31:16];

    // p = 0 carries the previous slot's LSB (one-bit I2S delay); past bit 16 is padding.
    if (pos == '0)              ser_bit = last_bit_q;
    else if (pos <= BW'(16))    ser_bit = sample[4'(5'd16 - 5'(pos))];
    else                        ser_bit = 1'b0;

    if (enable) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) sclk_d = ~sclk_q;
      if (fall) begin
        bit_cnt_d = bit_next;
        lrck_d    = slot;
        sdata_d   = ser_bit;
        frame_d   = frame_nxt;
        if (pos == LB_POS) last_bit_d = sample[0];
      end
      frame_start_d = load;
      underrun_d    = load & ~pending_valid_q;
      if (load) pending_valid_d = 1'b0;
      if (sample_valid) begin
        pending_d       = {sample_l, sample_r};
        pending_valid_d = 1'b1;
        overrun_d       = pending_valid_q & ~load;
      end
    end else begin
      div_cnt_d = '0;
      sclk_d    = 1'b0;
      lrck_d    = 1'b0;
      sdata_d   = 1'b0;
      bit_cnt_d = BIT_LAST;
      if (sample_valid) begin
        pending_d       = {sample_l, sample_r};
        pending_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q       <= '0;
      bit_cnt_q       <= BIT_LAST;
      sclk_q          <= 1'b0;
      lrck_q          <= 1'b0;
      sdata_q         <= 1'b0;
      last_bit_q      <= 1'b0;
      frame_q         <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      frame_start_q   <= 1'b0;
      underrun_q      <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      div_cnt_q       <= div_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      sclk_q          <= sclk_d;
      lrck_q          <= lrck_d;
      sdata_q         <= sdata_d;
      last_bit_q      <= last_bit_d;
      frame_q         <= frame_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      frame_start_q   <= frame_start_d;
      underrun_q      <= underrun_d;
      overrun_q       <= overrun_d;
    end
  end

  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign overrun     = overrun_q;
  assign i2s_sclk    = sclk_q;
  assign i2s_lrck    = lrck_q;
  assign i2s_sdata   = sdata_q;

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Stereo I2S transmitter. Serialises the parallel signed 16-bit L/R samples produced by the audio filter chain onto a three-wire I2S link (sclk, lrck, sdata) for the external DAC/HDMI audio path.
- Decouples the producer through a one-deep pending register with a ready pulse per frame.
- Reports underrun and overrun conditions.

Parameters:
- SCLK_DIV, 4: clk cycles per sclk half-period; legal range >= 1.
- SLOT_BITS, 16: sclk periods per channel slot; legal range 16..32.
- MUTE_ON_UNDERRUN, 0: on underrun, 1 transmits zeros and 0 repeats the previous frame.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  link enable; 0 parks the link.
- sample_l  in  16  signed left sample.
- sample_r  in  16  signed right sample.
- sample_valid  in  1  one-clk strobe; captures sample_l/sample_r into the pending register.
- frame_start  out  1  one-clk pulse when a frame is loaded; upstream uses it as its sample_ce.
- underrun  out  1  one-clk pulse; frame loaded with no pending sample.
- overrun  out  1  one-clk pulse; pending sample overwritten before it was consumed.
- i2s_sclk  out  1  bit clock.
- i2s_lrck  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first, changes on sclk falling edge.

Behaviour:
- Reset (async, reset_n = 0):
  - All outputs = 0.
  - div_cnt = 0; bit_cnt = 2*SLOT_BITS-1; pending_valid = 0; frame register = 0; last_bit = 0.
- Divider:
  - div_cnt counts 0..SCLK_DIV-1 while enable = 1.
  - At terminal count, i2s_sclk toggles and div_cnt returns to 0.
  - A toggle 1->0 is a "fall event". i2s_sclk, i2s_lrck and i2s_sdata all update on the same clk edge (registered, no combinational paths to outputs).
- Bit counter:
  - Advances on each fall event, 0..2*SLOT_BITS-1, then wraps to 0.
  - The first fall event after reset or enable rises: first at 2*SCLK_DIV clks.
- Frame load, on the fall event where bit_cnt wraps to 0:
  - If pending_valid = 1: frame <= pending; pending_valid <= 0.
  - If pending_valid = 0: frame <= MUTE_ON_UNDERRUN ? 0 : frame (unchanged), and underrun pulses.
  - frame_start pulses on the same clk in both cases.
- Serial mapping, for bit_cnt = b: slot s = b / SLOT_BITS, position p = b mod SLOT_BITS.
  - i2s_lrck = s.
  - p = 0: i2s_sdata = last_bit, the LSB of the previous slot's sample. This is the I2S one-bit delay; the left slot uses the previous frame's right LSB.
  - 1 <= p <= 16: i2s_sdata = sample_s[16-p].
  - p > 16: i2s_sdata = 0 (padding).
  - last_bit is updated with sample_s[0] when p = 16 is driven.
- Pending register:
  - sample_valid = 1 writes pending <= {sample_l, sample_r} and sets pending_valid.
  - If pending_valid was already 1 and no frame load occurs that clk, overrun pulses; the newest data wins.
- Simultaneous sample_valid and frame load: the load takes the old pending contents; the new sample is written to pending, pending_valid stays 1, no overrun. If pending_valid was 0, underrun pulses and the new sample waits for the next frame.
- enable = 0:
  - Synchronously clears div_cnt, sclk, lrck and sdata to 0, and sets bit_cnt = 2*SLOT_BITS-1.
  - Frame register, last_bit and pending are retained.
  - No pulses are generated.
  - Re-enabling restarts exactly as after reset.
- Reset asserted mid-frame: immediate return to reset state; the partial frame is discarded.
- Frame period = 2*SLOT_BITS*2*SCLK_DIV clks. Latency from sample_valid to its MSB on sdata is at most two frames plus 2*SCLK_DIV clks.

Test Plan:
- SCLK_DIV=2, SLOT_BITS=16. Release reset; apply sample_valid with L=16'hA5C3, R=16'h0F01 before the first fall event.
  -> frame_start at clk 4; sclk period 4 clks; lrck low for 64 clks then high for 64.
  -> Left bits 1..16 = A5C3 MSB first; right bits 1..16 = 0F01; left p=0 bit = 0.
  -> Second frame's left p=0 bit = 1 (right LSB).
- No sample_valid for two frames, MUTE_ON_UNDERRUN=0 -> underrun pulses at each frame_start; sdata repeats A5C3/0F01. With MUTE_ON_UNDERRUN=1 -> all-zero data.
- Two sample_valid strobes (1111/2222 then 3333/4444) inside one frame -> one overrun pulse; next frame carries 3333/4444.
- sample_valid coincident with frame_start, pending holding 5555/6666, new 7777/8888.
  -> Current frame carries 5555/6666; next frame carries 7777/8888; no overrun, no underrun.
- SLOT_BITS=24, SCLK_DIV=1 -> 96-clk frame; positions 17..23 of each slot drive 0; lrck toggles every 48 clks.
- Deassert enable mid right slot, then reassert after 10 clks.
  -> Outputs 0 while disabled, no pulses; restart with frame_start 2*SCLK_DIV clks after enable.
- Drop reset_n mid-frame -> outputs 0 asynchronously; the pending sample is lost.
